// File: rtl/branch_predict_ctrl.sv
// Branch predictor for the 5-stage RV32I pipeline: direct-mapped 2-bit BHT with tagged BTB
// looked up in IF, resolved against the branch unit in EX, with branch/mispredict counters.
module branch_predict_ctrl #(
  parameter int          IDX_W    = 6,
  parameter logic [1:0]  CNT_INIT = 2'b01,
  parameter int          PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       PCF,
  output logic              PredTakenF,
  output logic [31:0]       PredPCF,
  input  logic              BrValidE,
  input  logic              StallE,
  input  logic [31:0]       PCE,
  input  logic              PredTakenE,
  input  logic [31:0]       PredPCE,
  input  logic              BranchE,
  input  logic [31:0]       BrTargetE,
  output logic              RedirectE,
  output logic [31:0]       RedirectPCE,
  output logic              FlushD,
  output logic              FlushE,
  output logic [PERF_W-1:0] BrCount,
  output logic [PERF_W-1:0] MissCount
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [1:0]       cnt_q   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [31:0]      tgt_q   [DEPTH];

  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_f;
  logic [TAG_W-1:0] tag_e;
  logic             hit_f;
  logic             hit_e;
  logic             res;
  logic             mispredict;
  logic             replace;
  logic [1:0]       cnt_e;
  logic [1:0]       cnt_next;

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];

  // IF lookup reads the registered table only, so an EX write to the same
  // index becomes visible one cycle later.
  assign hit_f      = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign PredTakenF = hit_f && cnt_q[idx_f][1];
  assign PredPCF    = PredTakenF ? tgt_q[idx_f] : (PCF + 32'd4);

  assign res        = BrValidE && !StallE;
  assign mispredict = res && ((BranchE != PredTakenE) ||
                              (BranchE && (PredPCE != BrTargetE)));

  // Redirect and flushes are held low while reset is asserted.
  assign RedirectE   = mispredict && rst_n;
  assign FlushD      = RedirectE;
  assign FlushE      = RedirectE;
  assign RedirectPCE = RedirectE ? (BranchE ? BrTargetE : (PCE + 32'd4)) : 32'd0;

  assign hit_e   = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign replace = BranchE && !hit_e;
  assign cnt_e   = cnt_q[idx_e];

  always_comb begin
    cnt_next = cnt_e;
    if (replace) begin
      cnt_next = 2'b10;
    end else if (BranchE) begin
      if (cnt_e != 2'b11) cnt_next = cnt_e + 2'd1;
    end else begin
      if (cnt_e != 2'b00) cnt_next = cnt_e - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) cnt_q[k] <= CNT_INIT;
      valid_q <= '0;
    end else if (res) begin
      cnt_q[idx_e] <= cnt_next;
      if (BranchE) valid_q[idx_e] <= 1'b1;
    end
  end

  // Tags and targets need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (res && BranchE) begin
      tag_q[idx_e] <= tag_e;
      tgt_q[idx_e] <= BrTargetE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BrCount   <= '0;
      MissCount <= '0;
    end else if (res) begin
      if (BrCount != '1) BrCount <= BrCount + 1'b1;
      if (mispredict && (MissCount != '1)) MissCount <= MissCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: vector table with a scoreboard queue,
// plus hand-written reset and counter-saturation sequences.
module tb_branch_predict_ctrl;

  localparam int PERF_W = 4;
  localparam int W      = 66;

  logic              clk;
  logic              rst_n;
  logic [31:0]       PCF;
  logic              PredTakenF;
  logic [31:0]       PredPCF;
  logic              BrValidE;
  logic              StallE;
  logic [31:0]       PCE;
  logic              PredTakenE;
  logic [31:0]       PredPCE;
  logic              BranchE;
  logic [31:0]       BrTargetE;
  logic              RedirectE;
  logic [31:0]       RedirectPCE;
  logic              FlushD;
  logic              FlushE;
  logic [PERF_W-1:0] BrCount;
  logic [PERF_W-1:0] MissCount;

  branch_predict_ctrl #(.IDX_W(6), .CNT_INIT(2'b01), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredTakenF(PredTakenF), .PredPCF(PredPCF),
    .BrValidE(BrValidE), .StallE(StallE), .PCE(PCE), .PredTakenE(PredTakenE),
    .PredPCE(PredPCE), .BranchE(BranchE), .BrTargetE(BrTargetE), .RedirectE(RedirectE),
    .RedirectPCE(RedirectPCE), .FlushD(FlushD), .FlushE(FlushE),
    .BrCount(BrCount), .MissCount(MissCount)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pcf;
    logic        bv;
    logic        st;
    logic [31:0] pce;
    logic        pt;
    logic [31:0] ppc;
    logic        br;
    logic [31:0] tgt;
    logic        e_red;
    logic [31:0] e_rpc;
    logic        e_ptf;
    logic [31:0] e_ppcf;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] exp_q[$];
  int           checks;
  int           errors;
  int           exp_br;
  int           exp_miss;
  localparam int CMAX = (1 << PERF_W) - 1;

  function automatic vec_t mk(logic [31:0] pcf, logic bv, logic st, logic [31:0] pce,
                              logic pt, logic [31:0] ppc, logic br, logic [31:0] tgt,
                              logic e_red, logic [31:0] e_rpc, logic e_ptf,
                              logic [31:0] e_ppcf);
    vec_t v;
    v.pcf = pcf; v.bv = bv; v.st = st; v.pce = pce; v.pt = pt; v.ppc = ppc;
    v.br = br; v.tgt = tgt; v.e_red = e_red; v.e_rpc = e_rpc; v.e_ptf = e_ptf;
    v.e_ppcf = e_ppcf;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_ex(input logic bv, input logic st, input logic [31:0] pce,
                          input logic pt, input logic [31:0] ppc, input logic br,
                          input logic [31:0] tgt);
    BrValidE = bv; StallE = st; PCE = pce; PredTakenE = pt; PredPCE = ppc;
    BranchE = br; BrTargetE = tgt;
  endtask

  // driver: called just after a rising edge; checks at the falling edge
  task automatic apply(input vec_t v, input int step);
    logic [W-1:0] e;
    logic [W-1:0] a;
    PCF = v.pcf;
    drive_ex(v.bv, v.st, v.pce, v.pt, v.ppc, v.br, v.tgt);
    exp_q.push_back({v.e_red, v.e_red ? v.e_rpc : 32'd0, v.e_ptf, v.e_ppcf});
    @(negedge clk);
    e = exp_q.pop_front();
    a = {RedirectE, RedirectE ? RedirectPCE : 32'd0, PredTakenF, PredPCF};
    check($sformatf("step%0d_outputs", step), a, e);
    check($sformatf("step%0d_flush", step), {64'd0, FlushD, FlushE}, {64'd0, v.e_red, v.e_red});
    check($sformatf("step%0d_counts", step), {58'd0, BrCount, MissCount},
          {58'd0, exp_br[PERF_W-1:0], exp_miss[PERF_W-1:0]});
    if (v.bv && !v.st && exp_br < CMAX) exp_br++;
    if (v.e_red && exp_miss < CMAX) exp_miss++;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] A = 32'h100;
  localparam logic [31:0] B = 32'h200;  // aliases A at index 0 with a different tag
  localparam logic [31:0] C = 32'h104;

  initial begin
    checks = 0; errors = 0; exp_br = 0; exp_miss = 0;
    rst_n = 1'b0;
    PCF = A;
    drive_ex(1'b1, 1'b0, A, 1'b0, A + 4, 1'b1, 32'h80);  // would mispredict if not in reset
    #12;
    check("reset_ptf",   {65'd0, PredTakenF}, {65'd0, 1'b0});
    check("reset_ppcf",  {34'd0, PredPCF}, {34'd0, 32'h104});
    check("reset_redir", {63'd0, RedirectE, FlushD, FlushE}, 66'd0);
    check("reset_cnts",  {58'd0, BrCount, MissCount}, 66'd0);
    drive_ex(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //            pcf bv st pce pt ppc     br tgt      red rpc      ptf ppcf
    tbl.push_back(mk(A, 0, 0, 0, 0, 0,      0, 0,      0, 0,       0, A + 4));
    tbl.push_back(mk(A, 1, 0, A, 0, A + 4,  1, 32'h80, 1, 32'h80,  0, A + 4));
    tbl.push_back(mk(A, 1, 0, A, 1, 32'h80, 1, 32'h80, 0, 0,       1, 32'h80));
    tbl.push_back(mk(A, 1, 0, A, 1, 32'h80, 1, 32'h80, 0, 0,       1, 32'h80));
    tbl.push_back(mk(A, 1, 0, A, 1, 32'h80, 1, 32'h80, 0, 0,       1, 32'h80));
    tbl.push_back(mk(A, 1, 0, A, 1, 32'h80, 0, 32'h80, 1, A + 4,   1, 32'h80));
    tbl.push_back(mk(A, 0, 0, 0, 0, 0,      0, 0,      0, 0,       1, 32'h80));
    tbl.push_back(mk(A, 1, 0, A, 1, 32'h80, 1, 32'h90, 1, 32'h90,  1, 32'h80));
    tbl.push_back(mk(A, 0, 0, 0, 0, 0,      0, 0,      0, 0,       1, 32'h90));
    tbl.push_back(mk(A, 1, 0, A, 1, 32'h90, 0, 32'h90, 1, A + 4,   1, 32'h90));
    tbl.push_back(mk(A, 1, 0, A, 1, 32'h90, 0, 32'h90, 1, A + 4,   1, 32'h90));
    tbl.push_back(mk(A, 0, 0, 0, 0, 0,      0, 0,      0, 0,       0, A + 4));
    tbl.push_back(mk(A, 1, 0, A, 0, A + 4,  0, 32'h90, 0, 0,       0, A + 4));
    tbl.push_back(mk(A, 1, 0, A, 0, A + 4,  0, 32'h90, 0, 0,       0, A + 4));
    tbl.push_back(mk(A, 1, 0, A, 0, A + 4,  1, 32'h90, 1, 32'h90,  0, A + 4));
    tbl.push_back(mk(A, 0, 0, 0, 0, 0,      0, 0,      0, 0,       0, A + 4));
    tbl.push_back(mk(A, 1, 0, A, 0, A + 4,  1, 32'h90, 1, 32'h90,  0, A + 4));
    tbl.push_back(mk(A, 0, 0, 0, 0, 0,      0, 0,      0, 0,       1, 32'h90));
    tbl.push_back(mk(A, 1, 0, B, 0, B + 4,  1, 32'h40, 1, 32'h40,  1, 32'h90));
    tbl.push_back(mk(A, 0, 0, 0, 0, 0,      0, 0,      0, 0,       0, A + 4));
    tbl.push_back(mk(B, 0, 0, 0, 0, 0,      0, 0,      0, 0,       1, 32'h40));
    tbl.push_back(mk(B, 1, 1, B, 1, 32'h40, 0, 32'h40, 0, 0,       1, 32'h40));
    tbl.push_back(mk(B, 1, 1, B, 1, 32'h40, 0, 32'h40, 0, 0,       1, 32'h40));
    tbl.push_back(mk(B, 1, 0, B, 1, 32'h40, 0, 32'h40, 1, B + 4,   1, 32'h40));
    tbl.push_back(mk(B, 0, 0, 0, 0, 0,      0, 0,      0, 0,       0, B + 4));
    tbl.push_back(mk(C, 1, 0, C, 0, C + 4,  0, 32'h300, 0, 0,      0, C + 4));
    tbl.push_back(mk(C, 1, 0, C, 0, C + 4,  1, 32'h300, 1, 32'h300, 0, C + 4));
    tbl.push_back(mk(C, 0, 0, 0, 0, 0,      0, 0,      0, 0,       1, 32'h300));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // asynchronous reset in mid-cycle while a mispredicting branch is in EX
    PCF = C;
    drive_ex(1'b1, 1'b0, C, 1'b0, C + 4, 1'b1, 32'h500);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ptf",   {65'd0, PredTakenF}, {65'd0, 1'b0});
    check("midrst_ppcf",  {34'd0, PredPCF}, {34'd0, C + 4});
    check("midrst_redir", {63'd0, RedirectE, FlushD, FlushE}, 66'd0);
    check("midrst_cnts",  {58'd0, BrCount, MissCount}, 66'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_ex(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    check("postrst_ptf",  {65'd0, PredTakenF}, {65'd0, 1'b0});
    check("postrst_cnts", {58'd0, BrCount, MissCount}, 66'd0);
    @(posedge clk);
    #1;

    // counter saturation: random-PC mispredicts, both counters must stop at all-ones
    exp_br = 0; exp_miss = 0;
    for (int i = 0; i < CMAX + 5; i++) begin
      logic [31:0] pc;
      pc = {$urandom_range(0, 32'hFFFF), 2'b00};
      PCF = pc;
      drive_ex(1'b1, 1'b0, pc, 1'b0, pc + 4, 1'b1, pc + 32'h40);
      @(negedge clk);
      check($sformatf("sat%0d_redir", i), {65'd0, RedirectE}, {65'd0, 1'b1});
      check($sformatf("sat%0d_rpc", i), {34'd0, RedirectPCE}, {34'd0, pc + 32'h40});
      check($sformatf("sat%0d_cnts", i), {58'd0, BrCount, MissCount},
            {58'd0, exp_br[PERF_W-1:0], exp_miss[PERF_W-1:0]});
      if (exp_br < CMAX) exp_br++;
      if (exp_miss < CMAX) exp_miss++;
      @(posedge clk);
      #1;
    end
    drive_ex(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    check("sat_final", {58'd0, BrCount, MissCount},
          {58'd0, CMAX[PERF_W-1:0], CMAX[PERF_W-1:0]});
    check("idle_redir", {63'd0, RedirectE, FlushD, FlushE}, 66'd0);
    check("sb_empty", {34'd0, 32'(exp_q.size())}, 66'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
